lsu_mem_stage: RTL
==================

# lsu_mem_stage

Memory-access stage of the RV64I pipeline, directly downstream of the execute-stage ALU. It takes the ALU result as an effective address for loads and stores, and drives a 64-bit data-memory port with variable-latency handshake. It aligns and sign/zero-extends load data and passes non-memory results through to writeback. It stalls the upstream stage while a memory access is outstanding.

## Interface
- No parameters; XLEN fixed at 64, data bus 64 bits, 8 byte lanes.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_opcode  in  5  instr[6:2]; 00000 = load, 01000 = store, anything else = pass-through
- in_func3  in  3  width/sign select
- in_alu_out  in  64  ALU result (effective address for load/store)
- in_store_data  in  64  rs2 value for stores
- in_rd  in  5  destination register
- in_wen  in  1  instruction writes rd
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  64  {addr[63:3], 3'b000}
- mem_wdata  out  64  lane-shifted store data
- mem_wstrb  out  8  byte-lane enables; 0 for reads
- mem_rdata  in  64  read data, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion pulse
- out_valid  out  1  result to writeback
- out_ready  in  1  writeback accepts
- out_data  out  64  writeback value, or faulting address on exception
- out_rd  out  5  destination register
- out_wen  out  1  write enable; forced 0 for stores and exceptions
- out_exc  out  1  misaligned or illegal-width access

## Operation
- **States:** IDLE, MEM_WAIT, OUT_HOLD.
- **in_ready:** equals (state != MEM_WAIT) && (!out_valid || out_ready).
- **Acceptance:** an instruction is accepted when in_valid && in_ready. Let a = in_alu_out[2:0].
- **Pass-through op:** the next cycle gives out_valid=1, out_data=in_alu_out, and out_rd/out_wen copied from the inputs.
- **Illegal width:** load func3=111, or store func3>=100.
- **Misaligned:**
  - H (func3[1:0]=01) with a[0]=1;
  - W (10) with a[1:0]!=0;
  - D (11) with a!=0.
- **Faulting access:** for illegal or misaligned accesses, no memory request is made. The next cycle gives out_valid=1, out_exc=1, out_wen=0, out_data=address.
- **Legal access:** the next cycle asserts mem_req and enters MEM_WAIT.
  - mem_we=1 for stores.
  - wstrb for stores: SB = 0x01<<a, SH = 0x03<<a, SW = 0x0F<<a, SD = 0xFF.
  - mem_wdata = in_store_data << (8*a).
  - All mem_* outputs stay stable until mem_ack.
- **MEM_WAIT completion:** on the mem_ack cycle, mem_req drops on the next edge and the stage registers the result, giving out_valid=1 the next cycle.
- **Load data:** r = mem_rdata >> (8*a), then extended:
  - LB sext r[7:0]; LH sext r[15:0]; LW sext r[31:0]; LD r;
  - LBU zext r[7:0]; LHU zext r[15:0]; LWU zext r[31:0].
- **Store result:** out_wen=0 and out_data=address.
- **OUT_HOLD:** out_valid high while !out_ready; all out_* outputs stay stable. A new instruction may be accepted in the same cycle out_ready=1 (back-to-back throughput for pass-through ops).
- **Stray ack:** mem_ack outside MEM_WAIT is ignored.

## Timing
- **Reset values:** every output is 0, including in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, out_valid, out_data, out_rd, out_wen, out_exc. State = IDLE.
- **After reset:** in_ready goes to 1 in the first cycle after rst deasserts.
- **Reset mid-access:** rst in MEM_WAIT drops mem_req on that edge and discards the access.
- **Latency, pass-through or exception:** 1 cycle, accept to out_valid.
- **Latency, memory access:** accept at cycle T gives mem_req at T+1. With mem_ack at cycle K, out_valid occurs at K+1. With zero-wait memory (ack at T+1), out_valid occurs at T+2.
- **No forward combinational paths:** out_valid and mem_req are registered. in_ready is the only combinational output, depending on state, out_valid and out_ready.

## Test plan
- **Pass-through ADD:** alu_out=0x1234, rd=5, wen=1, out_ready=1. Expect out_valid the next cycle with out_data=0x1234, out_rd=5, out_wen=1, out_exc=0; mem_req stays 0.
- **SB at a=6:** store_data=0xAB. Expect mem_wstrb=0x40, mem_wdata[55:48]=0xAB, mem_addr low 3 bits=0, mem_we=1. With ack after 3 cycles, out_valid arrives 1 cycle later with out_wen=0.
- **Byte load at a=3:** mem_rdata=0x00000000_80000000 gives byte 0x80.
  - LB: out_data=0xFFFFFFFF_FFFFFF80.
  - LBU: out_data=0x80.
  - LW at a=4 with rdata=0x80000000_00000000: out_data=0xFFFFFFFF_80000000.
- **Misaligned accesses:** LW at address 0x1002 and SD at 0x1004. Each gives out_exc=1, out_wen=0, out_data equal to the address, and mem_req is never asserted.
- **Backpressure and stall:** hold out_ready=0 for 4 cycles. out_* stays stable and in_ready=0; during MEM_WAIT in_ready=0 regardless of out_ready. A stray mem_ack in IDLE has no effect.
- **Reset mid-access:** assert rst while mem_req=1. The next cycle has mem_req=0, out_valid=0, in_ready=0, followed by in_ready=1 once rst deasserts. A late mem_ack after reset is ignored.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - RV64I memory-access stage: load/store to a variable-latency data port.
// Aligns and extends load data, flags misaligned/illegal widths, passes other results through.
module lsu_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_opcode,
  input  logic [2:0]  in_func3,
  input  logic [63:0] in_alu_out,
  input  logic [63:0] in_store_data,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_exc
);
  typedef enum logic [1:0] {IDLE, MEM_WAIT, OUT_HOLD} state_e;

  state_e      state_q, state_d;
  logic        ready_en_q, ready_en_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [7:0]  mem_wstrb_q, mem_wstrb_d;
  logic [2:0]  pend_a_q, pend_a_d, pend_f3_q, pend_f3_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic        pend_wen_q, pend_wen_d, pend_store_q, pend_store_d;
  logic        out_valid_q, out_valid_d, out_wen_q, out_wen_d, out_exc_q, out_exc_d;
  logic [63:0] out_data_q, out_data_d;
  logic [4:0]  out_rd_q, out_rd_d;

  logic [2:0]  a;
  logic        is_load, is_store, is_mem, illegal, misaligned, accept;
  logic [63:0] pend_addr, load_rsh, load_ext;
  logic [7:0]  store_strb;

  assign a        = in_alu_out[2:0];
  assign is_load  = (in_opcode == 5'b00000);
  assign is_store = (in_opcode == 5'b01000);
  assign is_mem   = is_load || is_store;
  assign illegal  = (is_load && in_func3 == 3'b111) || (is_store && in_func3[2]);
  assign accept   = in_valid && in_ready;

  // in_ready is the only combinational output; ready_en_q keeps it low through reset
  assign in_ready = ready_en_q && (state_q != MEM_WAIT) && (!out_valid_q || out_ready);

  always_comb begin
    misaligned = 1'b0;
    store_strb = 8'hFF;
    case (in_func3[1:0])
      2'b00: store_strb = 8'h01 << a;
      2'b01: begin misaligned = a[0];          store_strb = 8'h03 << a; end
      2'b10: begin misaligned = (a[1:0] != 0); store_strb = 8'h0F << a; end
      default: misaligned = (a != 3'b000);
    endcase
  end

  assign pend_addr = {mem_addr_q[63:3], pend_a_q};
  assign load_rsh  = mem_rdata >> {pend_a_q, 3'b000};

  always_comb begin
    load_ext = load_rsh;
    case (pend_f3_q)
      3'b000: load_ext = {{56{load_rsh[7]}},  load_rsh[7:0]};
      3'b001: load_ext = {{48{load_rsh[15]}}, load_rsh[15:0]};
      3'b010: load_ext = {{32{load_rsh[31]}}, load_rsh[31:0]};
      3'b100: load_ext = {56'd0, load_rsh[7:0]};
      3'b101: load_ext = {48'd0, load_rsh[15:0]};
      3'b110: load_ext = {32'd0, load_rsh[31:0]};
      default: load_ext = load_rsh;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ready_en_d   = 1'b1;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    pend_a_d     = pend_a_q;
    pend_f3_d    = pend_f3_q;
    pend_rd_d    = pend_rd_q;
    pend_wen_d   = pend_wen_q;
    pend_store_d = pend_store_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_rd_d     = out_rd_q;
    out_wen_d    = out_wen_q;
    out_exc_d    = out_exc_q;
    if (state_q == MEM_WAIT) begin
      if (mem_ack) begin
        mem_req_d   = 1'b0;
        out_valid_d = 1'b1;
        out_data_d  = pend_store_q ? pend_addr : load_ext;
        out_rd_d    = pend_rd_q;
        out_wen_d   = pend_wen_q && !pend_store_q;
        out_exc_d   = 1'b0;
        state_d     = OUT_HOLD;
      end
    end else begin
      if (out_ready) out_valid_d = 1'b0;
      if (accept && is_mem && !illegal && !misaligned) begin
        mem_req_d    = 1'b1;
        mem_we_d     = is_store;
        mem_addr_d   = {in_alu_out[63:3], 3'b000};
        mem_wdata_d  = is_store ? (in_store_data << {a, 3'b000}) : 64'd0;
        mem_wstrb_d  = is_store ? store_strb : 8'h00;
        pend_a_d     = a;
        pend_f3_d    = in_func3;
        pend_rd_d    = in_rd;
        pend_wen_d   = in_wen;
        pend_store_d = is_store;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_alu_out;
        out_rd_d    = in_rd;
        out_wen_d   = is_mem ? 1'b0 : in_wen;
        out_exc_d   = is_mem;
      end
      state_d = mem_req_d ? MEM_WAIT : (out_valid_d ? OUT_HOLD : IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ready_en_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 64'd0;
      mem_wdata_q  <= 64'd0;
      mem_wstrb_q  <= 8'h00;
      pend_a_q     <= 3'd0;
      pend_f3_q    <= 3'd0;
      pend_rd_q    <= 5'd0;
      pend_wen_q   <= 1'b0;
      pend_store_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 64'd0;
      out_rd_q     <= 5'd0;
      out_wen_q    <= 1'b0;
      out_exc_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_en_q   <= ready_en_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      pend_a_q     <= pend_a_d;
      pend_f3_q    <= pend_f3_d;
      pend_rd_q    <= pend_rd_d;
      pend_wen_q   <= pend_wen_d;
      pend_store_q <= pend_store_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_rd_q     <= out_rd_d;
      out_wen_q    <= out_wen_d;
      out_exc_q    <= out_exc_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_rd    = out_rd_q;
  assign out_wen   = out_wen_q;
  assign out_exc   = out_exc_q;
endmodule
